// File: rtl/fifo_byte_drain.sv
// rtl/fifo_byte_drain.sv - FIFO read-side drain that serializes words into beats
//
// Pops WIDTH-bit words from an async FIFO read port and emits each one
// MSB-first as NBEATS = WIDTH/OUT_WIDTH beats on a valid/ready stream.
// WIDTH must be an integer multiple of OUT_WIDTH, with NBEATS >= 2.
//
// Ports:
//   rdclk        FIFO read-side clock
//   rst_n        synchronous active-low reset
//   fifo_empty   FIFO empty flag
//   fifo_rden    FIFO read enable (combinational)
//   fifo_rddata  FIFO read data, valid the cycle after fifo_rden
//   out_data     current beat
//   out_valid    beat valid
//   out_ready    downstream accepts beat
//   out_last     final beat of the current word
//   words_read   count of words popped, wraps
module fifo_byte_drain #(
  parameter int WIDTH     = 64,
  parameter int OUT_WIDTH = 8,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 rdclk,
  input  logic                 rst_n,
  input  logic                 fifo_empty,
  output logic                 fifo_rden,
  input  logic [WIDTH-1:0]     fifo_rddata,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_last,
  output logic [CNT_WIDTH-1:0] words_read
);

  localparam int NBEATS = WIDTH / OUT_WIDTH;
  localparam int BW     = $clog2(NBEATS);
  localparam logic [BW-1:0] LAST_BEAT = BW'(NBEATS - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_SEND
  } state_t;

  state_t               state, state_nxt;
  logic [WIDTH-1:0]     sr, sr_nxt;
  logic [BW-1:0]        beat, beat_nxt;
  logic [CNT_WIDTH-1:0] words_q;
  logic                 in_send;
  logic                 at_last;
  logic                 hs;

  always_ff @(posedge rdclk) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      sr      <= '0;
      beat    <= '0;
      words_q <= '0;
    end else begin
      state <= state_nxt;
      sr    <= sr_nxt;
      beat  <= beat_nxt;
      if (fifo_rden) begin
        words_q <= words_q + CNT_WIDTH'(1);
      end
    end
  end

  always_comb begin
    in_send = (state == ST_SEND);
    at_last = (beat == LAST_BEAT);
    hs      = in_send && out_ready;

    // Pop either from idle, or in the same cycle the last beat of the held
    // word is accepted, so only one word is ever outstanding. rst_n gates it
    // so nothing is popped while the FIFO itself is held in reset.
    fifo_rden = rst_n && !fifo_empty && ((state == ST_IDLE) || (hs && at_last));

    out_valid = in_send;
    out_last  = in_send && at_last;
    out_data  = in_send ? sr[WIDTH-1 -: OUT_WIDTH] : '0;

    state_nxt = state;
    sr_nxt    = sr;
    beat_nxt  = beat;

    case (state)
      ST_IDLE: begin
        if (fifo_rden) begin
          state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // Read data lands one cycle after rden.
        sr_nxt    = fifo_rddata;
        beat_nxt  = '0;
        state_nxt = ST_SEND;
      end
      ST_SEND: begin
        if (hs) begin
          if (!at_last) begin
            sr_nxt   = sr << OUT_WIDTH;
            beat_nxt = beat + 1'b1;
          end else begin
            state_nxt = fifo_rden ? ST_WAIT : ST_IDLE;
          end
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  assign words_read = words_q;

endmodule

// File: tb/tb_fifo_byte_drain.sv
// tb/tb_fifo_byte_drain.sv - self-checking bench for fifo_byte_drain
module tb_fifo_byte_drain;

  logic        rdclk;
  logic        rst_n;
  logic        fifo_empty;
  logic        fifo_rden;
  logic [63:0] fifo_rddata;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic [31:0] words_read;

  fifo_byte_drain dut (
    .rdclk       (rdclk),
    .rst_n       (rst_n),
    .fifo_empty  (fifo_empty),
    .fifo_rden   (fifo_rden),
    .fifo_rddata (fifo_rddata),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_last    (out_last),
    .words_read  (words_read)
  );

  initial rdclk = 1'b0;
  always #5 rdclk = ~rdclk;

  // Reference model: FIFO contents, and the byte stream still owed downstream.
  logic [63:0] fifo_q[$];
  logic [7:0]  exp_q[$];
  logic        last_q[$];
  int          model_words = 0;

  int checks = 0, errors = 0, cyc = 0;
  int hs_cnt = 0, hs_total = 0;
  int rden_cyc = -100, last_hs_cyc = 0;
  int ready_mode = 0;          // 0: stall control, 1: random, 2: held low
  int stall_at = -1, stall_len = 0, stalled = 0;
  logic [7:0] stall_data, first_beat_v, final_beat_v;
  bit   valid_prev = 0, hold_pending = 0, b2b_seen = 0;
  logic [7:0] data_prev;
  logic last_prev;
  int   valid_cycles = 0;

  typedef struct {
    logic [63:0] word;
    int          stall_at;
    int          stall_len;
    logic [7:0]  exp_stall;
    int          exp_span;     // rden cycle to last-beat handshake cycle
    logic [7:0]  exp_first;
    logic [7:0]  exp_final;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  task automatic push_word(input logic [63:0] w);
    fifo_q.push_back(w);
    fifo_empty = 1'b0;
  endtask

  task automatic cycle();
    bit rst_s, rden_s;
    logic [63:0] w;
    @(negedge rdclk);
    cyc++;
    rst_s  = !rst_n;
    rden_s = fifo_rden;
    chk("rden_while_empty", fifo_rden & fifo_empty, 0);
    if (rst_s) chk("rden_in_reset", fifo_rden, 0);
    chk("words_read", words_read, model_words);
    if (out_valid) valid_cycles++;
    if (hold_pending) begin
      chk("stall_valid_hold", out_valid, 1);
      chk("stall_data_hold", out_data, data_prev);
      chk("stall_last_hold", out_last, last_prev);
    end
    if (!rst_s && out_valid && !valid_prev) chk("valid_latency", cyc - rden_cyc, 2);
    if (rden_s) rden_cyc = cyc;
    if (!rst_s && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        fail_now("unexpected_beat");
      end else begin
        chk("beat_data", out_data, exp_q.pop_front());
        chk("beat_last", out_last, last_q.pop_front());
      end
      if (hs_cnt == 0) first_beat_v = out_data;
      hs_total++;
      hs_cnt++;
      if (out_last) begin
        final_beat_v = out_data;
        last_hs_cyc  = cyc;
        if (fifo_rden) b2b_seen = 1;
        hs_cnt = 0;
      end
    end
    if (!rst_s && out_valid && !out_ready && hs_cnt == stall_at) begin
      stalled++;
      stall_data = out_data;
    end
    hold_pending = !rst_s && out_valid && !out_ready;
    data_prev    = out_data;
    last_prev    = out_last;
    valid_prev   = !rst_s && out_valid;

    @(posedge rdclk);
    #1;
    if (rst_s) begin
      exp_q.delete();
      last_q.delete();
      fifo_q.delete();
      model_words = 0;
      hs_cnt = 0;
      fifo_rddata = {$urandom, $urandom};
    end else if (rden_s && fifo_q.size() > 0) begin
      w = fifo_q.pop_front();
      fifo_rddata = w;
      model_words++;
      for (int b = 0; b < 8; b++) begin
        exp_q.push_back(w[63 - 8*b -: 8]);
        last_q.push_back(b == 7);
      end
    end else begin
      fifo_rddata = {$urandom, $urandom};
    end
    fifo_empty = (fifo_q.size() == 0) || (ready_mode == 1 && $urandom_range(0, 4) == 0);
    case (ready_mode)
      1:       out_ready = ($urandom_range(0, 3) != 0);
      2:       out_ready = 1'b0;
      default: out_ready = !(hs_cnt == stall_at && stalled < stall_len);
    endcase
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((fifo_q.size() != 0 || exp_q.size() != 0) && n < budget) begin
      cycle();
      n++;
    end
    if (n >= budget) fail_now("drain_timeout");
    cycle();
    chk("idle_after_drain", out_valid, 0);
  endtask

  task automatic do_reset(input int n);
    ready_mode = 2;
    out_ready  = 1'b0;
    rst_n      = 1'b0;
    for (int i = 0; i < n; i++) cycle();
    rst_n = 1'b1;
    #3;
    chk("reset_valid", out_valid, 0);
    chk("reset_last", out_last, 0);
    chk("reset_data", out_data, 0);
    chk("reset_words", words_read, 0);
    chk("reset_rden", fifo_rden, 0);
    ready_mode = 0;
    stall_at   = -1;
    out_ready  = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout (cycle %0d)", cyc);
    $fatal(1, "simulation did not finish");
  end

  initial begin
    int c0, h0, n;
    vecs[0] = '{64'h0123456789ABCDEF, -1, 0, 8'h00,  9, 8'h01, 8'hEF};
    vecs[1] = '{64'h0123456789ABCDEF,  2, 3, 8'h45, 12, 8'h01, 8'hEF};
    vecs[2] = '{64'hA5A5A5A5A5A5A5A5,  0, 1, 8'hA5, 10, 8'hA5, 8'hA5};
    vecs[3] = '{64'hFF00FF00FF00FF00,  7, 2, 8'h00, 11, 8'hFF, 8'h00};
    vecs[4] = '{64'h8000000000000001,  4, 5, 8'h00, 14, 8'h80, 8'h01};

    rst_n       = 1'b0;
    fifo_empty  = 1'b1;
    fifo_rddata = '0;
    out_ready   = 1'b0;
    do_reset(2);

    // Empty FIFO with toggling ready: nothing may happen.
    valid_cycles = 0;
    for (int i = 0; i < 100; i++) begin
      out_ready  = i[0];
      fifo_empty = 1'b1;
      @(negedge rdclk);
      cyc++;
      chk("empty_rden", fifo_rden, 0);
      if (out_valid) valid_cycles++;
      @(posedge rdclk);
      #1;
    end
    chk("empty_valid_cycles", valid_cycles, 0);
    chk("empty_words_read", words_read, 0);
    out_ready = 1'b1;

    // Directed single words, with and without a stall.
    foreach (vecs[i]) begin
      stall_at  = vecs[i].stall_at;
      stall_len = vecs[i].stall_len;
      stalled   = 0;
      hs_cnt    = 0;
      h0        = hs_total;
      out_ready = !(stall_at == 0);
      push_word(vecs[i].word);
      drain(100);
      chk("vec_span", last_hs_cyc - rden_cyc, vecs[i].exp_span);
      chk("vec_handshakes", hs_total - h0, 8);
      chk("vec_first_beat", first_beat_v, vecs[i].exp_first);
      chk("vec_final_beat", final_beat_v, vecs[i].exp_final);
      chk("vec_stall_cycles", stalled, stall_len);
      if (stall_len > 0) chk("vec_stall_data", stall_data, vecs[i].exp_stall);
    end
    stall_at = -1;

    // Back-to-back: second pop on the first word's last beat, one bubble.
    do_reset(1);
    b2b_seen = 0;
    c0 = cyc;
    push_word(64'h1111111111111111);
    push_word(64'h2222222222222222);
    drain(100);
    chk("b2b_rden_on_last", b2b_seen, 1);
    chk("b2b_span", last_hs_cyc - c0, 19);
    chk("b2b_words_read", words_read, 2);

    // Reset after beat 3 of a word, then a clean word.
    push_word(64'h0123456789ABCDEF);
    n = 0;
    while (hs_cnt < 4 && n < 50) begin
      cycle();
      n++;
    end
    if (n >= 50) fail_now("midword_timeout");
    do_reset(1);
    h0 = hs_total;
    push_word(64'hA5A5A5A5A5A5A5A5);
    drain(100);
    chk("post_reset_beats", hs_total - h0, 8);
    chk("post_reset_words", words_read, 1);

    // Randomized traffic, ready and empty flag both jittered.
    ready_mode = 1;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 7) == 0) push_word({$urandom, $urandom});
      cycle();
    end
    drain(3000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_byte_drain.md
Name: fifo_byte_drain

Overview:
- Read-side consumer for the async FIFO, running entirely in the rdclk domain.
- Pops WIDTH-bit words from the FIFO read port (rden/empty/rddata) and serializes each word MSB-first into OUT_WIDTH-bit beats on a valid/ready stream.
- Typically feeds the host USB byte interface.
- Owns all FIFO read-side handshaking so downstream logic never sees empty or read-latency details.

Parameters:
- WIDTH, 64, FIFO word width. Must be an integer multiple of OUT_WIDTH.
- OUT_WIDTH, 8, output beat width.
- CNT_WIDTH, 32, width of the words_read counter.
- Derived: NBEATS = WIDTH/OUT_WIDTH (must be >= 2). Beat index width = $clog2(NBEATS).

Ports:
- rdclk  in  1  clock, shared with the FIFO read port.
- rst_n  in  1  reset, synchronous, active-low.
- fifo_empty  in  1  FIFO empty flag.
- fifo_rden  out  1  FIFO read enable.
- fifo_rddata  in  WIDTH  FIFO read data; valid the cycle after fifo_rden.
- out_data  out  OUT_WIDTH  current beat.
- out_valid  out  1  beat valid.
- out_ready  in  1  downstream accepts beat.
- out_last  out  1  high with the final beat of each word.
- words_read  out  CNT_WIDTH  count of FIFO words popped.

Behaviour:
- States:
  - IDLE: no word held.
  - WAIT: rden issued, data arriving.
  - SEND: shift register loaded, beats being emitted.
- Registers: shift register sr[WIDTH-1:0], beat counter beat, words_read.
- fifo_rden (combinational) = rst_n && !fifo_empty && (state==IDLE || (state==SEND && out_ready && beat==NBEATS-1)).
- Reset (rst_n low at a rdclk edge): state=IDLE, beat=0, sr=0, words_read=0.
  - Outputs during and after reset: out_valid=0, out_last=0, out_data=0, fifo_rden=0.
  - Reset mid-word discards the partial word; no further beats of it are emitted.
  - Reset is applied together with the FIFO reset.
- IDLE: out_valid=0. If fifo_rden, next state WAIT.
- WAIT: out_valid=0. At the edge, sr<=fifo_rddata, beat<=0, next state SEND. Unconditional, one cycle.
- SEND:
  - Outputs: out_valid=1, out_data=sr[WIDTH-1 -: OUT_WIDTH], out_last=(beat==NBEATS-1).
  - On handshake (out_valid && out_ready):
    - Not last beat: sr<=sr<<OUT_WIDTH, beat<=beat+1, stay in SEND.
    - Last beat with fifo_rden high: next state WAIT. The back-to-back pop leaves one bubble cycle.
    - Last beat with fifo_rden low: next state IDLE.
  - Without a handshake, all state holds. out_data and out_last stay stable while out_valid && !out_ready.
- Latency: fifo_rden cycle N, then WAIT at N+1, then first beat valid at N+2.
  - From fifo_empty falling while in IDLE: out_valid rises 2 cycles later.
- Throughput: NBEATS+1 cycles per word under continuous ready and a non-empty FIFO.
- words_read increments by 1 on every cycle with fifo_rden=1. Wraps modulo 2^CNT_WIDTH with no saturation.
- Never asserts fifo_rden while fifo_empty=1. At most one word is outstanding; no prefetch beyond it.
- fifo_empty asserting during SEND has no effect on the held word.
- out_ready is ignored outside SEND.

Test Plan:
- Single word: FIFO holds 0x0123456789ABCDEF, out_ready=1.
  - Expect one fifo_rden pulse.
  - out_valid rises 2 cycles after the pulse.
  - Beats 01,23,45,67,89,AB,CD,EF on 8 consecutive cycles; out_last only with EF.
  - words_read=1; then IDLE with out_valid=0.
- Backpressure: same word, out_ready low for 3 cycles at beat 2 (value 0x45).
  - out_data holds 0x45 and out_valid stays 1 for the stall.
  - Sequence resumes intact; 8 handshakes total.
- Back-to-back: two words 0x1111111111111111 and 0x2222222222222222, out_ready=1.
  - Second fifo_rden is asserted in the same cycle as the 0x11 last beat.
  - Exactly one out_valid=0 cycle, then eight 0x22 beats; words_read=2.
- Empty FIFO: fifo_empty=1 for 100 cycles, out_ready toggling.
  - fifo_rden=0 and out_valid=0 throughout; words_read=0.
- Reset mid-word: assert rst_n low for 1 cycle after beat 3.
  - Next cycle: out_valid=0, out_last=0, out_data=0, words_read=0.
  - With the FIFO then loaded with 0xA5A5A5A5A5A5A5A5, output is exactly eight 0xA5 beats with no remnant of the old word.
